// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Registers the winning requester's address/data and decodes a one-hot write enable.
module regfile_write_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    addr_in,
    input  logic [DW*NREQ-1:0]   data_in,
    input  logic                 rf_ready,
    output logic [NREQ-1:0]      grant,
    output logic [31:0]          wr_en,
    output logic [4:0]           wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [4:0]      addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;

    logic [NREQ-1:0] eligible;
    logic            found;
    logic [PW-1:0]   win;
    int unsigned     cand;

    // The requester granted in the ending cycle sits out this edge.
    assign eligible = req & ~grant_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!found && eligible[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (rf_ready && found) begin
            state_d      = StIssue;
            grant_d[win] = 1'b1;
            addr_d       = addr_in[32'(win)*5 +: 5];
            data_d       = data_in[32'(win)*DW +: DW];
            ptr_d        = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Write enable is derived from registered state only; register 0 is never written.
    always_comb begin
        wr_en = '0;
        if (state_q == StIssue) begin
            wr_en    = 32'd1 << addr_q;
            wr_en[0] = 1'b0;
        end
    end

    assign grant   = grant_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign busy    = |eligible;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [5*NREQ-1:0]   addr_in;
    logic [DW*NREQ-1:0]  data_in;
    logic                rf_ready;
    logic [NREQ-1:0]     grant;
    logic [31:0]         wr_en;
    logic [4:0]          wr_addr;
    logic [DW-1:0]       wr_data;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_ptr;
    int          m_gnt;   // -1 when no grant
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    regfile_write_arbiter #(
        .NREQ(NREQ),
        .DW  (DW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .addr_in (addr_in),
        .data_in (data_in),
        .rf_ready(rf_ready),
        .grant   (grant),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [NREQ-1:0] exp_grant();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_gnt >= 0) g[m_gnt] = 1'b1;
        return g;
    endfunction

    function automatic logic [31:0] exp_wr_en();
        logic [31:0] e;
        e = 32'd0;
        if (m_gnt >= 0 && m_addr != 5'd0) e = 32'd1 << m_addr;
        return e;
    endfunction

    // Advance the model with the inputs as they stand, then take one clock edge.
    task automatic step();
        int w;
        if (reset) begin
            m_ptr  = 0;
            m_gnt  = -1;
            m_addr = '0;
            m_data = '0;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (w < 0 && req[i] && i != m_gnt) w = i;
            end
            if (rf_ready && w >= 0) begin
                m_gnt  = w;
                m_addr = addr_in[5*w +: 5];
                m_data = data_in[DW*w +: DW];
                m_ptr  = (w + 1) % NREQ;
            end else begin
                m_gnt = -1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rf_ready = 1'b1;
        req      = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            addr_in[5*i +: 5]   = 5'(3 + 2*i);
            data_in[DW*i +: DW] = 32'h100 + 32'(i);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant);
            else n_pass++;
            n_checks++;
            if (wr_en !== 32'd0) $display("FAIL reset_wr_en: got %h want 0", wr_en);
            else n_pass++;
            n_checks++;
            if (wr_addr !== 5'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr);
            else n_pass++;
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL first_grant: got %b want 0001", grant);
        else n_pass++;
        n_checks++;
        if (wr_en !== 32'h8) $display("FAIL first_wr_en: got %h want 8", wr_en);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0]  g;
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0;
            step();
            g = 4'b0001 << (k + 1);
            e = 32'd1 << (3 + 2*(k + 1));
            n_checks++;
            if (grant !== g) $display("FAIL rr_grant[%0d]: got %b want %b", k + 1, grant, g);
            else n_pass++;
            n_checks++;
            if (wr_en !== e) $display("FAIL rr_wr_en[%0d]: got %h want %h", k + 1, wr_en, e);
            else n_pass++;
            n_checks++;
            if (wr_data !== 32'h100 + 32'(k + 1))
                $display("FAIL rr_wr_data[%0d]: got %h want %h", k + 1, wr_data,
                         32'h100 + 32'(k + 1));
            else n_pass++;
        end
        req[3] = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL rr_drain: got %b want 0000", grant);
        else n_pass++;
    endtask

    task automatic test_single_req();
        addr_in[14:10] = 5'd31;
        data_in[95:64] = 32'hDEADBEEF;
        req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c % 2 == 0) begin
                n_checks++;
                if (grant !== 4'b0100) $display("FAIL single_grant[%0d]: got %b want 0100", c, grant);
                else n_pass++;
                n_checks++;
                if (wr_en !== 32'h8000_0000)
                    $display("FAIL single_wr_en[%0d]: got %h want 80000000", c, wr_en);
                else n_pass++;
                n_checks++;
                if (wr_data !== 32'hDEADBEEF)
                    $display("FAIL single_wr_data[%0d]: got %h want deadbeef", c, wr_data);
                else n_pass++;
                n_checks++;
                if (busy !== 1'b0) $display("FAIL single_busy[%0d]: got %b want 0", c, busy);
                else n_pass++;
            end else begin
                n_checks++;
                if (grant !== 4'b0000) $display("FAIL single_gap[%0d]: got %b want 0000", c, grant);
                else n_pass++;
                n_checks++;
                if (wr_en !== 32'd0) $display("FAIL single_gap_en[%0d]: got %h want 0", c, wr_en);
                else n_pass++;
                n_checks++;
                if (busy !== 1'b1) $display("FAIL single_gap_busy[%0d]: got %b want 1", c, busy);
                else n_pass++;
            end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_reg_zero();
        addr_in[9:5]   = 5'd0;
        data_in[63:32] = 32'h1234;
        req = 4'b0010;
        step();
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL r0_grant: got %b want 0010", grant);
        else n_pass++;
        n_checks++;
        if (wr_en !== 32'd0) $display("FAIL r0_wr_en: got %h want 0", wr_en);
        else n_pass++;
        n_checks++;
        if (wr_addr !== 5'd0) $display("FAIL r0_wr_addr: got %0d want 0", wr_addr);
        else n_pass++;
        n_checks++;
        if (wr_data !== 32'h1234) $display("FAIL r0_wr_data: got %h want 1234", wr_data);
        else n_pass++;
        req = '0;
        step();
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL r0_consumed: got %b want 0000", grant);
        else n_pass++;
    endtask

    task automatic test_rf_ready();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        rf_ready = 1'b0;
        req      = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000) $display("FAIL stall_grant[%0d]: got %b want 0000", c, grant);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b1) $display("FAIL stall_busy[%0d]: got %b want 1", c, busy);
            else n_pass++;
        end
        rf_ready = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL ready_grant0: got %b want 0001", grant);
        else n_pass++;
        req[0] = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0100) $display("FAIL ready_grant2: got %b want 0100", grant);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        // Grant 0100 is on the outputs now; reset lands in this cycle.
        reset = 1'b1;
        req   = 4'b0101;
        step();
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL abort_grant: got %b want 0000", grant);
        else n_pass++;
        n_checks++;
        if (wr_en !== 32'd0) $display("FAIL abort_wr_en: got %h want 0", wr_en);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL abort_ptr: got %b want 0001", grant);
        else n_pass++;
        req = '0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step();
            n_checks++;
            if (grant !== exp_grant())
                $display("FAIL rand_grant[%0d]: got %b want %b", c, grant, exp_grant());
            else n_pass++;
            n_checks++;
            if (wr_en !== exp_wr_en())
                $display("FAIL rand_wr_en[%0d]: got %h want %h", c, wr_en, exp_wr_en());
            else n_pass++;
            n_checks++;
            if (wr_addr !== m_addr)
                $display("FAIL rand_wr_addr[%0d]: got %0d want %0d", c, wr_addr, m_addr);
            else n_pass++;
            n_checks++;
            if (wr_data !== m_data)
                $display("FAIL rand_wr_data[%0d]: got %h want %h", c, wr_data, m_data);
            else n_pass++;
            n_checks++;
            if (busy !== |(req & ~exp_grant()))
                $display("FAIL rand_busy[%0d]: got %b want %b", c, busy, |(req & ~exp_grant()));
            else n_pass++;
            // Requesters obey the hold-until-granted contract.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt == i) begin
                    if ($urandom_range(3) == 0) begin
                        addr_in[5*i +: 5]   = 5'($urandom);
                        data_in[DW*i +: DW] = $urandom;
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    req[i]              = 1'b1;
                    addr_in[5*i +: 5]   = 5'($urandom);
                    data_in[DW*i +: DW] = $urandom;
                end
            end
            rf_ready = ($urandom_range(3) != 0);
            reset    = ($urandom_range(40) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        addr_in  = '0;
        data_in  = '0;
        rf_ready = 1'b1;
        m_ptr    = 0;
        m_gnt    = -1;
        m_addr   = '0;
        m_data   = '0;
        test_reset();
        test_round_robin();
        test_single_req();
        test_reg_zero();
        test_rf_ready();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
